// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Defining MULDIV_SIGNED_EN enables two's-complement operation selected by op_i[1].
module muldiv_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_pend_q, dz_pend_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dz_q, dz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   fin_prod;
    logic [WIDTH-1:0]     fin_q, fin_r, dz_rem;

`ifdef MULDIV_SIGNED_EN
    logic neg_p_q, neg_p_d;  // product / quotient negate
    logic neg_r_q, neg_r_d;  // remainder negate
    logic a_neg, b_neg;

    always_comb begin
        a_neg    = op_i[1] & a_i[WIDTH-1];
        b_neg    = op_i[1] & b_i[WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        fin_prod = neg_p_q ? -step : step;
        fin_q    = neg_p_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        fin_r    = neg_r_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        dz_rem   = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op_i[1];

    always_comb begin
        a_mag    = a_i;
        b_mag    = b_i;
        fin_prod = step;
        fin_q    = step[WIDTH-1:0];
        fin_r    = step[2*WIDTH-1:WIDTH];
        dz_rem   = acc_q[WIDTH-1:0];
    end
`endif

    // acc holds {high, low}: multiply {partial product, multiplier}, divide {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        div_ge   = ~rem_diff[WIDTH];
        if (is_div_q) begin
            step = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        dz_pend_d = dz_pend_q;
        result_d  = result_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_p_d   = neg_p_q;
        neg_r_d   = neg_r_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d   = StRun;
                    busy_d    = 1'b1;
                    cnt_d     = CntW'(WIDTH);
                    is_div_d  = op_i[0];
                    dz_pend_d = op_i[0] && (b_i == '0);
                    opnd_d    = op_i[0] ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op_i[0] ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
                    neg_p_d   = a_neg ^ b_neg;
                    neg_r_d   = a_neg;
`endif
                end
            end
            StRun: begin
                if (dz_pend_q) begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    dz_d     = 1'b1;
                    result_d = {dz_rem, {WIDTH{1'b1}}};
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_d  = StDone;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        dz_d     = 1'b0;
                        result_d = is_div_q ? {fin_r, fin_q} : fin_prod;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
        // flush overrides everything, including a simultaneous start
        if (flush_i) begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
            result_d = result_q;
            dz_d     = dz_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            dz_pend_q <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_p_q   <= 1'b0;
            neg_r_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            dz_pend_q <= dz_pend_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MULDIV_SIGNED_EN
            neg_p_q   <= neg_p_d;
            neg_r_q   <= neg_r_d;
`endif
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign div_by_zero_o = dz_q;

endmodule
